display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//   Upstream feeder for the per-digit seven-segment driver on the 3-digit display.
//   Accepts a binary value (e.g. score) on a load strobe and converts it to three BCD
//   digits with a sequential shift-add-3 (double-dabble) engine. Holds the digits and
//   time-multiplexes them by rotating select and presenting the matching digit_val.
// PARAMETERS
//   CLK_DIV    50000  src_clk cycles per digit refresh slot; legal range >= 2
//   DIV_WIDTH  16     prescaler counter width; must satisfy 2**DIV_WIDTH >= CLK_DIV
// PORTS
//   src_clk    in   1   system clock; all state changes on posedge
//   src_rst    in   1   synchronous, active-low reset
//   load       in   1   single-cycle request to convert value; honoured only when busy=0
//   value      in   10  unsigned binary value to display
//   busy       out  1   conversion in progress; load ignored while high
//   done       out  1   one-cycle pulse when new digits are committed to display regs
//   select     out  2   digit slot: 0=ones, 1=tens, 2=hundreds; 3 never driven
//   digit_val  out  4   BCD digit (0-9) for the current select slot
// BEHAVIOUR
//   Reset (src_rst=0 at a posedge): state=IDLE, busy=0, done=0, select=0, prescaler=0,
//     all three digit regs=0, so digit_val=0. Reset wins over any concurrent load.
//   Reset mid-conversion aborts it. The digit regs are cleared to 0, not the old value.
//   FSM IDLE:
//     - busy=0.
//     - On load=1 at edge k: capture sat = (value>999) ? 999 : value.
//     - Clear the 12-bit BCD accumulator and the 4-bit shift counter.
//     - Go to CONVERT; busy=1 from edge k.
//   FSM CONVERT, per cycle:
//     - Add 3 to each BCD nibble >= 5.
//     - Shift {bcd,bin} left 1 (bin MSB enters bcd LSB).
//     - Increment the counter.
//   Conversion end: on the 10th shift (edge k+10):
//     - Write the corrected nibbles into the ones/tens/hundreds digit regs.
//     - Pulse done=1 for the following cycle; busy=0.
//     - Return to IDLE.
//     - Latency: load sampled at edge k -> digits and done visible after edge k+10.
//   Load timing:
//     - load while busy=1 is dropped. It is not queued.
//     - load in the cycle right after done (state IDLE) is accepted.
//   Display regs hold the previous value for the whole conversion (no partial or
//     flicker digits). Digit regs only ever hold 0-9.
//   Scan prescaler:
//     - Free-running 0..CLK_DIV-1, then wraps to 0. Independent of the FSM.
//     - On the wrap, select advances 0->1->2->0 (never 3).
//     - The first advance occurs CLK_DIV cycles after reset release.
//   digit_val is combinational from select and the digit regs: (0:ones, 1:tens, 2:hundreds).
//     The downstream driver registers select and digit_val together, so they stay aligned.
//   No leading-zero blanking: 7 displays as 0,0,7.
// TESTING
//   1 Reset held 3 cycles then released -> select=0, digit_val=0, busy=0, done=0.
//   2 load=1, value=123 (CLK_DIV=4) -> busy 10 cycles, done pulse once; scan shows
//     slots 0/1/2 = 3/2/1.
//   3 value=1023 and value=999 -> both display 9,9,9; value=0 -> 0,0,0;
//     value=500 -> 0,0,5.
//   4 load 456 then load 789 three cycles later -> second ignored, display 6,5,4;
//     reload 789 the cycle after done -> display 9,8,7 after 10 more cycles.
//   5 CLK_DIV=4, run 30 cycles -> select changes exactly every 4 cycles, sequence
//     0,1,2,0,...; digit_val matches slot each cycle.
//   6 Display 321 loaded, load 654, assert reset at conversion cycle 5 -> after reset
//     all digits 0, busy=0, no done pulse.

Source files
------------

// File: rtl/display_scan_if.sv
// ---------------------------------------------------------------------------
// display_scan_if
//   Bundles the load/value request and the scan outputs of display_scan_ctrl.
//   master : the block that requests conversions and consumes the scan outputs
//   slave  : display_scan_ctrl itself
//   Signals
//     load      1   single-cycle conversion request
//     value     10  unsigned binary value to display
//     busy      1   conversion in progress
//     done      1   one-cycle pulse when new digits are committed
//     select    2   current digit slot (0=ones, 1=tens, 2=hundreds)
//     digit_val 4   BCD digit for the current slot
// ---------------------------------------------------------------------------
interface display_scan_if;
    logic       load;
    logic [9:0] value;
    logic       busy;
    logic       done;
    logic [1:0] select;
    logic [3:0] digit_val;

    modport master (
        output load,
        output value,
        input  busy,
        input  done,
        input  select,
        input  digit_val
    );

    modport slave (
        input  load,
        input  value,
        output busy,
        output done,
        output select,
        output digit_val
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//   Converts a 10-bit binary value (saturated to 999) into three BCD digits
//   with a sequential shift-add-3 engine, holds them, and time-multiplexes
//   them onto select/digit_val for the seven-segment driver.
//
//   Ports
//     src_clk   in   system clock, all state on posedge
//     src_rst   in   synchronous active-low reset
//     bus       slave modport of display_scan_if (load/value in,
//               busy/done/select/digit_val out)
//
//   FSM states
//     state      | meaning
//     -----------+---------------------------------------------------------
//     S_IDLE     | waiting for load; digit regs shown unchanged
//     S_CONVERT  | one add-3 + shift per cycle, 10 cycles, then commit
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int DIV_WIDTH = 16
) (
    input  logic          src_clk,
    input  logic          src_rst,
    display_scan_if.slave bus
);

    typedef enum logic {
        S_IDLE,
        S_CONVERT
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLK_DIV - 1);

    state_t               r_state;
    logic [9:0]           r_bin;
    logic [11:0]          r_bcd;
    logic [3:0]           r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [3:0]           r_ones;
    logic [3:0]           r_tens;
    logic [3:0]           r_hund;
    logic [DIV_WIDTH-1:0] r_presc;
    logic [1:0]           r_select;

    logic [11:0]          w_bcd_adj;
    logic [21:0]          w_shift;
    logic [9:0]           w_sat;
    logic [3:0]           w_digit;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign w_sat = (bus.value > 10'd999) ? 10'd999 : bus.value;

    assign w_bcd_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    // bin MSB moves into the BCD LSB; the dropped top bit is always 0 for inputs <= 999
    assign w_shift   = {w_bcd_adj, r_bin} << 1;

    always_ff @(posedge src_clk) begin
        if (!src_rst) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ones  <= '0;
            r_tens  <= '0;
            r_hund  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_bin   <= w_sat;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_bcd <= w_shift[21:10];
                    r_bin <= w_shift[9:0];
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        // commit straight from the final shift so the display never sees partial digits
                        r_ones  <= w_shift[13:10];
                        r_tens  <= w_shift[17:14];
                        r_hund  <= w_shift[21:18];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Scan prescaler runs regardless of conversion activity
    always_ff @(posedge src_clk) begin
        if (!src_rst) begin
            r_presc  <= '0;
            r_select <= 2'd0;
        end else if (r_presc == DIV_LAST) begin
            r_presc  <= '0;
            r_select <= (r_select == 2'd2) ? 2'd0 : r_select + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_comb begin
        w_digit = 4'd0;
        case (r_select)
            2'd0:    w_digit = r_ones;
            2'd1:    w_digit = r_tens;
            2'd2:    w_digit = r_hund;
            default: w_digit = 4'd0;
        endcase
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.select    = r_select;
    assign bus.digit_val = w_digit;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    localparam int CLK_DIV = 4;

    typedef struct {
        logic [9:0]  val;
        logic [11:0] bcd;   // expected {hundreds, tens, ones}
    } vec_t;

    logic src_clk = 1'b0;
    logic src_rst = 1'b0;

    display_scan_if bus();

    display_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .DIV_WIDTH (4)
    ) dut (
        .src_clk (src_clk),
        .src_rst (src_rst),
        .bus     (bus)
    );

    always #5 src_clk = ~src_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;           // posedges since the last reset edge
    logic [11:0] exp_q[$];   // scoreboard of pending conversions
    logic [11:0] shown = 12'h000;
    vec_t vecs[8];

    always @(posedge src_clk) begin
        if (!src_rst) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [3:0] dig(input logic [11:0] w, input logic [1:0] s);
        case (s)
            2'd0:    return w[3:0];
            2'd1:    return w[7:4];
            2'd2:    return w[11:8];
            default: return 4'hF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic do_load(input logic [9:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        @(posedge src_clk);
        #1 bus.load = 1'b0;
    endtask

    // Waits for done; counts busy cycles and checks the displayed digits stay frozen meanwhile
    task automatic wait_done(output int bc, output bit ok);
        bc = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge src_clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) bc++;
            chk("hold_digit", 16'(bus.digit_val), 16'(dig(shown, bus.select)));
        end
        if (!ok) chk("done_timeout", 16'd0, 16'd1);
    endtask

    task automatic scan_check(input string nm);
        for (int i = 0; i < 3 * CLK_DIV; i++) begin
            @(negedge src_clk);
            chk({nm, "_sel"}, 16'(bus.select), 16'((cyc / CLK_DIV) % 3));
            chk({nm, "_digit"}, 16'(bus.digit_val), 16'(dig(shown, bus.select)));
        end
    endtask

    task automatic pop_commit();
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 16'd1, 16'd0);
        end else begin
            shown = exp_q.pop_front();
        end
    endtask

    initial begin
        int bc;
        bit ok;

        vecs[0] = '{10'd123,  12'h123};
        vecs[1] = '{10'd1023, 12'h999};
        vecs[2] = '{10'd999,  12'h999};
        vecs[3] = '{10'd0,    12'h000};
        vecs[4] = '{10'd500,  12'h500};
        vecs[5] = '{10'd7,    12'h007};
        vecs[6] = '{10'd58,   12'h058};
        vecs[7] = '{10'd1000, 12'h999};

        // Reset held 3 cycles with a concurrent load; reset must win
        bus.load  = 1'b1;
        bus.value = 10'd321;
        src_rst   = 1'b0;
        repeat (3) @(posedge src_clk);
        #1;
        bus.load = 1'b0;
        src_rst  = 1'b1;
        @(negedge src_clk);
        chk("rst_select", 16'(bus.select), 16'd0);
        chk("rst_digit",  16'(bus.digit_val), 16'd0);
        chk("rst_busy",   16'(bus.busy), 16'd0);
        chk("rst_done",   16'(bus.done), 16'd0);
        repeat (2) begin
            @(negedge src_clk);
            chk("rst_busy_after", 16'(bus.busy), 16'd0);
        end

        // Table-driven conversions
        foreach (vecs[i]) begin
            @(posedge src_clk);
            #1;
            do_load(vecs[i].val);
            exp_q.push_back(vecs[i].bcd);
            wait_done(bc, ok);
            if (ok) begin
                chk("busy_len", 16'(bc), 16'd10);
                pop_commit();
                @(negedge src_clk);
                chk("done_pulse_width", 16'(bus.done), 16'd0);
                scan_check("digits");
            end
        end

        // Load 123 then watch scan rotation for 30 cycles
        @(posedge src_clk);
        #1;
        do_load(10'd123);
        exp_q.push_back(12'h123);
        wait_done(bc, ok);
        if (ok) pop_commit();
        for (int i = 0; i < 30; i++) begin
            @(negedge src_clk);
            chk("rot_sel",   16'(bus.select), 16'((cyc / CLK_DIV) % 3));
            chk("rot_digit", 16'(bus.digit_val), 16'(dig(shown, bus.select)));
        end

        // 456 then 789 three cycles later: second dropped; reload right after done
        @(posedge src_clk);
        #1;
        do_load(10'd456);
        exp_q.push_back(12'h456);
        repeat (2) @(posedge src_clk);
        #1;
        do_load(10'd789);
        wait_done(bc, ok);
        if (ok) begin
            chk("busy_len_drop", 16'(bc), 16'd7);
            pop_commit();
            do_load(10'd789);        // issued in the done cycle
            exp_q.push_back(12'h789);
            wait_done(bc, ok);       // hold checks confirm 456 displayed meanwhile
            if (ok) begin
                chk("busy_len_reload", 16'(bc), 16'd10);
                pop_commit();
                scan_check("reload");
            end
        end

        // 321 displayed, load 654, reset at conversion cycle 5
        @(posedge src_clk);
        #1;
        do_load(10'd321);
        exp_q.push_back(12'h321);
        wait_done(bc, ok);
        if (ok) begin
            pop_commit();
            scan_check("pre_abort");
        end
        @(posedge src_clk);
        #1;
        do_load(10'd654);
        repeat (4) @(posedge src_clk);
        #1 src_rst = 1'b0;
        @(posedge src_clk);
        #1 src_rst = 1'b1;
        shown = 12'h000;
        for (int i = 0; i < 20; i++) begin
            @(negedge src_clk);
            chk("abort_busy",  16'(bus.busy), 16'd0);
            chk("abort_done",  16'(bus.done), 16'd0);
            chk("abort_sel",   16'(bus.select), 16'((cyc / CLK_DIV) % 3));
            chk("abort_digit", 16'(bus.digit_val), 16'(dig(shown, bus.select)));
        end
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
